// File: rtl/fifo_pkg.sv
// Shared types for the FIFO read-side stream adapter: read FSM states and a width helper.
package fifo_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } rd_state_t;

  // Width of a counter that must hold 0..n inclusive, for power-of-2 n.
  function automatic int clog2_p1(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/prefetch_buf.sv
// Prefetch buffer: DEPTH x DW sync FIFO, head visible with zero latency from registered storage.
// A push into a full buffer is taken only if a pop frees the slot in the same cycle; clear has priority.
module prefetch_buf
  import fifo_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = 16,
  parameter int LW    = clog2_p1(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  input  logic          clear,
  output logic          full,
  output logic [LW-1:0] level,
  output logic [DW-1:0] head
);

  localparam int PW = $clog2(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          w_pop_ok;
  logic          w_push_ok;

  assign full      = (r_level == LW'(DEPTH));
  assign w_pop_ok  = pop && (r_level != '0);
  assign w_push_ok = push && (!full || w_pop_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok && !clear) r_mem[r_wr_ptr] <= din;
  end

  // Storage is not reset, so an empty buffer presents zero rather than stale or unknown data.
  assign head  = (r_level != '0) ? r_mem[r_rd_ptr] : '0;
  assign level = r_level;

endmodule

// File: rtl/fifo_stream_reader.sv
// Turns simple_fifo's fixed-latency ord/odata_valid read port into a valid/ready stream.
// Reads are issued speculatively against buffer credit, so tready held high gives one word per cycle.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int LATENCY    = 2,
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 16,
  parameter int BUF_DEPTH  = 4
) (
  input  logic                            oclk,
  input  logic                            oreset_n,
  input  logic [ADDR_WIDTH:0]             ofull_count,
  output logic                            ord,
  input  logic [DATA_WIDTH-1:0]           odata,
  input  logic                            odata_valid,
  input  logic                            flush,
  output logic [DATA_WIDTH-1:0]           tdata,
  output logic                            tvalid,
  input  logic                            tready,
  output logic [clog2_p1(BUF_DEPTH)-1:0]  level,
  output logic                            buf_overrun
);

  localparam int LW = clog2_p1(BUF_DEPTH);
  localparam int IW = clog2_p1(LATENCY);
  localparam int SW = LW + IW;
  localparam int CW = ADDR_WIDTH + 1;

  rd_state_t             r_state;
  rd_state_t             w_state_nxt;
  logic [IW-1:0]         r_inflight;
  logic                  r_ord_q;
  logic                  r_overrun;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_room;
  logic                  w_has_avail;
  logic [LW-1:0]         w_level;
  logic [SW-1:0]         w_credit;
  logic [DATA_WIDTH-1:0] w_head;

  // r_inflight counts reads older than last cycle; r_ord_q covers last cycle's read,
  // so the sum below is every word that can still land in the buffer.
  assign w_credit    = SW'(r_inflight) + SW'(w_level) + SW'(r_ord_q);
  assign w_room      = (w_credit < SW'(BUF_DEPTH));
  // ofull_count does not yet reflect last cycle's read; a zero count never wraps to a huge avail.
  assign w_has_avail = (ofull_count > CW'(r_ord_q));
  assign w_pop       = tvalid && tready;

  always_comb begin
    w_state_nxt = r_state;
    ord         = 1'b0;
    w_push      = 1'b0;
    case (r_state)
      RUN: begin
        ord    = oreset_n && w_room && w_has_avail && !flush;
        w_push = odata_valid && !flush;
        if (flush) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if ((r_inflight == '0) && !r_ord_q && !flush) w_state_nxt = RUN;
      end
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge oclk or negedge oreset_n) begin
    if (!oreset_n) begin
      r_state    <= RUN;
      r_ord_q    <= 1'b0;
      r_inflight <= '0;
      r_overrun  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ord_q <= ord;
      if (r_ord_q && !odata_valid)
        r_inflight <= r_inflight + IW'(1);
      else if (!r_ord_q && odata_valid && (r_inflight != '0))
        r_inflight <= r_inflight - IW'(1);
      if (w_push && w_full && !w_pop) r_overrun <= 1'b1;
    end
  end

  prefetch_buf #(
    .DEPTH (BUF_DEPTH),
    .DW    (DATA_WIDTH),
    .LW    (LW)
  ) u_buf (
    .clk   (oclk),
    .rst_n (oreset_n),
    .push  (w_push),
    .din   (odata),
    .pop   (w_pop),
    .clear (flush),
    .full  (w_full),
    .level (w_level),
    .head  (w_head)
  );

  assign tvalid      = (w_level != '0);
  assign tdata       = w_head;
  assign level       = w_level;
  assign buf_overrun = r_overrun;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench: behavioural simple_fifo read port (LATENCY 2, lagged count) plus an in-order stream scoreboard.
module tb_fifo_stream_reader;

  localparam int LAT = 2;
  localparam int AW  = 13;
  localparam int DW  = 16;
  localparam int BD  = 4;
  localparam int LVW = 3;

  logic          oclk = 1'b0;
  logic          oreset_n = 1'b1;
  logic [AW:0]   ofull_count;
  logic          ord;
  logic [DW-1:0] odata;
  logic          odata_valid;
  logic          flush = 1'b0;
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready = 1'b0;
  logic [LVW-1:0] level;
  logic          buf_overrun;

  int checks = 0;
  int errors = 0;

  int unsigned src_total = 0;
  int unsigned rd_ptr    = 0;
  int unsigned rd_ptr_d  = 0;
  int unsigned exp_idx   = 0;
  logic [LAT-1:0] pipe_v;
  logic [DW-1:0]  pipe_d [LAT];
  logic           mon_en = 1'b0;
  logic           prev_stall = 1'b0;
  logic [DW-1:0]  prev_dat = '0;

  always #5 oclk = ~oclk;

  fifo_stream_reader #(
    .LATENCY    (LAT),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .BUF_DEPTH  (BD)
  ) dut (
    .oclk        (oclk),
    .oreset_n    (oreset_n),
    .ofull_count (ofull_count),
    .ord         (ord),
    .odata       (odata),
    .odata_valid (odata_valid),
    .flush       (flush),
    .tdata       (tdata),
    .tvalid      (tvalid),
    .tready      (tready),
    .level       (level),
    .buf_overrun (buf_overrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Source FIFO model: word value = read index; count is registered and lags ord by a cycle.
  assign ofull_count = (AW+1)'(src_total - rd_ptr_d);
  assign odata_valid = pipe_v[LAT-1];
  assign odata       = pipe_d[LAT-1];

  always @(posedge oclk or negedge oreset_n) begin
    if (!oreset_n) begin
      pipe_v   <= '0;
      rd_ptr_d <= rd_ptr;
    end else begin
      pipe_v    <= {pipe_v[LAT-2:0], ord};
      pipe_d[0] <= DW'(rd_ptr);
      for (int i = 1; i < LAT; i++) pipe_d[i] <= pipe_d[i-1];
      rd_ptr_d  <= rd_ptr;
      if (ord) rd_ptr <= rd_ptr + 1;
    end
  end

  always @(negedge oclk) begin
    if (!oreset_n) begin
      exp_idx    = rd_ptr;
      prev_stall = 1'b0;
    end else if (mon_en) begin
      if (prev_stall) begin
        check("hold_tvalid", 32'(tvalid), 32'd1);
        check("hold_tdata", 32'(tdata), 32'(prev_dat));
      end
      if (ord) check("no_underflow", 32'(src_total > rd_ptr), 32'd1);
      if (tvalid && tready) begin
        check("beat_order", 32'(tdata), 32'(exp_idx[15:0]));
        exp_idx = exp_idx + 1;
      end
      if (flush) exp_idx = rd_ptr;
      prev_stall = tvalid && !tready && !flush;
      prev_dat   = tdata;
    end
  end

  initial begin
    int          ords;
    int          gaps;
    int          n;
    int unsigned base;
    int unsigned max_lvl;

    src_total = 100;
    tready    = 1'b1;
    #1 oreset_n = 1'b0;
    repeat (2) @(posedge oclk);
    #1;
    check("rst_ord", 32'(ord), 32'd0);
    check("rst_tvalid", 32'(tvalid), 32'd0);
    check("rst_tdata", 32'(tdata), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_overrun", 32'(buf_overrun), 32'd0);
    mon_en   = 1'b1;
    oreset_n = 1'b1;

    // 1: deep source, sink always ready
    ords = 0;
    gaps = 0;
    for (int i = 0; i < 105; i++) begin
      @(negedge oclk);
      if (i < 100 && ord) ords++;
      if (i == 2) check("t1_tvalid_c2", 32'(tvalid), 32'd0);
      if (i == 3) check("t1_tvalid_c3", 32'(tvalid), 32'd1);
      if (i >= 3 && i <= 102 && !tvalid) gaps++;
    end
    check("t1_ord_cycles", 32'(ords), 32'd100);
    check("t1_tvalid_gaps", 32'(gaps), 32'd0);
    check("t1_words_out", exp_idx, 32'd100);
    check("t1_overrun", 32'(buf_overrun), 32'd0);

    // 2: only five words available
    @(posedge oclk); #1;
    base      = rd_ptr;
    src_total = base + 5;
    ords      = 0;
    repeat (20) begin
      @(negedge oclk);
      if (ord) ords++;
    end
    check("t2_ord_pulses", 32'(ords), 32'd5);
    check("t2_words_out", exp_idx - base, 32'd5);

    // 3: sink stalled, credit must cap issue at buffer depth
    @(posedge oclk); #1;
    tready    = 1'b0;
    base      = rd_ptr;
    src_total = src_total + 50;
    repeat (20) @(negedge oclk);
    check("t3_issued", rd_ptr - base, 32'd4);
    check("t3_level", 32'(level), 32'd4);
    check("t3_head", 32'(tdata), 32'(base[15:0]));
    @(posedge oclk); #1;
    tready = 1'b1;
    repeat (60) @(negedge oclk);
    check("t3_all_out", exp_idx, src_total);

    // 4: random backpressure over a full-size source
    @(posedge oclk); #1;
    src_total = src_total + 8192;
    max_lvl   = 0;
    n         = 0;
    while (exp_idx != src_total && n < 40000) begin
      tready = 1'($urandom_range(0, 1));
      @(negedge oclk);
      if (32'(level) > max_lvl) max_lvl = 32'(level);
      @(posedge oclk); #1;
      n++;
    end
    check("t4_all_out", exp_idx, src_total);
    check("t4_max_level_le_depth", 32'(max_lvl <= BD), 32'd1);
    check("t4_overrun", 32'(buf_overrun), 32'd0);

    // 5: flush with words buffered and reads in flight
    tready    = 1'b0;
    base      = rd_ptr;
    src_total = src_total + 50;
    n         = 0;
    do begin
      @(negedge oclk);
      n++;
    end while (level != 3'd1 && n < 20);
    check("t5_reach_level1", 32'(level), 32'd1);
    @(posedge oclk); #1;
    flush = 1'b1;
    @(negedge oclk);
    check("t5_pre_level", 32'(level), 32'd2);
    check("t5_ord_in_flush", 32'(ord), 32'd0);
    @(posedge oclk); #1;
    flush = 1'b0;
    @(negedge oclk);
    check("t5_tvalid_after", 32'(tvalid), 32'd0);
    check("t5_level_after", 32'(level), 32'd0);
    check("t5_ord_drain", 32'(ord), 32'd0);
    check("t5_reads_before", rd_ptr - base, 32'd4);
    repeat (12) @(negedge oclk);
    check("t5_refill_level", 32'(level), 32'd4);
    check("t5_first_after", 32'(tdata), 32'(base[15:0] + 16'd4));
    @(posedge oclk); #1;
    tready = 1'b1;
    repeat (60) @(negedge oclk);
    check("t5_all_out", exp_idx, src_total);

    // 6: asynchronous reset in the middle of a burst
    @(posedge oclk); #1;
    src_total = src_total + 100;
    repeat (10) @(negedge oclk);
    @(posedge oclk);
    #3 oreset_n = 1'b0;
    #1;
    check("t6_rst_ord", 32'(ord), 32'd0);
    check("t6_rst_tvalid", 32'(tvalid), 32'd0);
    check("t6_rst_tdata", 32'(tdata), 32'd0);
    check("t6_rst_level", 32'(level), 32'd0);
    repeat (2) @(posedge oclk);
    #1 oreset_n = 1'b1;
    repeat (150) @(negedge oclk);
    check("t6_all_out", exp_idx, src_total);
    check("t6_level_idle", 32'(level), 32'd0);
    check("t6_overrun", 32'(buf_overrun), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
